apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DATASIZE, default 32, APB data width in bits.
REQ-002 Parameter ADDRSIZE, default 32, APB address width in bits.
REQ-003 Parameter TIMEOUT, default 255, maximum ACCESS cycles waiting for PREADY before forced error completion.
REQ-004 PCLK  in  1  single clock for the block; all state updates on rising edge.
REQ-005 PRESET  in  1  reset, synchronous and active-high.
REQ-006 transfer  in  1  request available, high when the upstream read-side FIFO is not empty.
REQ-007 addr  in  ADDRSIZE, wdata  in  DATASIZE, strb  in  DATASIZE/8, pprot  in  3, write_read  in  1 (1=write): request fields from the deconcatenator.
REQ-008 rinc  out  1  FIFO pop strobe; request consumed at the clock edge where it is high.
REQ-009 PSEL, PENABLE, PWRITE  out  1 each; PADDR  out  ADDRSIZE; PWDATA  out  DATASIZE; PSTRB  out  DATASIZE/8; PPROT  out  3: APB requester signals.
REQ-010 PREADY  in  1, PRDATA  in  DATASIZE, PSLVERR  in  1: APB completer signals.
REQ-011 resp_winc  out  1, resp_rdata  out  DATASIZE, resp_slverr  out  1, resp_write  out  1: response push towards the return FIFO.
REQ-012 resp_wfull  in  1  return FIFO full.

Function
REQ-013 State machine SHALL have states IDLE, SETUP, ACCESS.
REQ-014 rinc SHALL be combinational: high iff !PRESET && transfer && !resp_wfull && (state==IDLE || (state==ACCESS && completion)).
REQ-015 On an edge with rinc high, addr/wdata/strb/pprot/write_read SHALL be registered onto PADDR/PWDATA/PSTRB/PPROT/PWRITE and state SHALL become SETUP.
REQ-016 SETUP: PSEL=1, PENABLE=0; next state ACCESS unconditionally.
REQ-017 ACCESS: PSEL=1, PENABLE=1; APB outputs SHALL hold stable until completion.
REQ-018 Completion in ACCESS: PREADY=1, or the wait counter reaching TIMEOUT.
REQ-019 On completion: next state SETUP if rinc high (back-to-back, PSEL stays 1), else IDLE (PSEL=0, PENABLE=0).
REQ-020 Minimum latency: rinc high in IDLE -> PSEL at +1 cycle -> PENABLE at +2 cycles -> earliest completion at +2 cycles.
REQ-021 Wait counter SHALL clear on entering ACCESS, increment each ACCESS cycle with PREADY=0, and saturate at TIMEOUT.
REQ-022 resp_winc SHALL pulse high for exactly the completion cycle, for reads and writes.
REQ-023 resp_rdata SHALL be PRDATA for reads and zero for writes or timeout; resp_slverr SHALL be PSLVERR, forced to 1 on timeout; resp_write SHALL be PWRITE.
REQ-024 A request SHALL NOT be accepted while resp_wfull=1, guaranteeing a completion is never blocked (single outstanding transfer).
REQ-025 transfer low or resp_wfull high at a completion SHALL return to IDLE; PADDR/PWDATA/PSTRB/PPROT/PWRITE SHALL retain the last values in IDLE.
REQ-026 Input request fields SHALL be ignored in every cycle where rinc is low.

Reset
REQ-027 PRESET high at any clock edge SHALL force IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, resp_winc, resp_rdata, resp_slverr, resp_write and the wait counter SHALL be 0.
REQ-028 Reset during SETUP or ACCESS SHALL abort the transfer with no response push; the popped request is lost.

Structure
REQ-029 The state enum (IDLE/SETUP/ACCESS) and the default TIMEOUT constant SHALL reside in the shared bridge package.
REQ-030 No sub-module; the wait counter is inline.

Verification
REQ-031 Write, transfer=1, addr=0x1000_0010, wdata=0xDEAD_BEEF, strb=0xF, PREADY=1 -> rinc at cycle 0, PSEL at cycle 1, PENABLE at cycle 2, resp_winc at cycle 2 with resp_write=1, resp_rdata=0.
REQ-032 Read addr=0x2000_0004, PREADY low for 3 ACCESS cycles, PRDATA=0x1234_5678 -> resp_winc once with resp_rdata=0x1234_5678, resp_slverr=0; APB outputs stable across the wait.
REQ-033 Two queued requests -> second rinc in the first completion cycle, PSEL stays high, SETUP immediately follows ACCESS.
REQ-034 PREADY held 0, TIMEOUT=4 -> completion after 4 ACCESS cycles with resp_slverr=1, resp_rdata=0, then IDLE.
REQ-035 resp_wfull=1 with transfer=1 -> rinc stays 0 and PSEL stays 0; release resp_wfull -> rinc on the same cycle.
REQ-036 PRESET asserted in ACCESS -> next cycle PSEL=0, PENABLE=0, resp_winc=0, state IDLE.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared bridge definitions: APB requester FSM states and the default PREADY timeout.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/apb_master.sv
// APB requester: pops one request from the upstream FIFO, runs SETUP/ACCESS, pushes one response.
// Single outstanding transfer; requests are only accepted when the response FIFO has room.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 32,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  transfer,
  input  logic [ADDRSIZE-1:0]   addr,
  input  logic [DATASIZE-1:0]   wdata,
  input  logic [DATASIZE/8-1:0] strb,
  input  logic [2:0]            pprot,
  input  logic                  write_read,
  output logic                  rinc,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDRSIZE-1:0]   PADDR,
  output logic [DATASIZE-1:0]   PWDATA,
  output logic [DATASIZE/8-1:0] PSTRB,
  output logic [2:0]            PPROT,
  input  logic                  PREADY,
  input  logic [DATASIZE-1:0]   PRDATA,
  input  logic                  PSLVERR,
  output logic                  resp_winc,
  output logic [DATASIZE-1:0]   resp_rdata,
  output logic                  resp_slverr,
  output logic                  resp_write,
  input  logic                  resp_wfull
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic           timed_out;
  logic           completion;

  // A completion is suppressed while PRESET is high so an aborted transfer never pushes a response.
  assign timed_out  = (state == ACCESS) && !PREADY && (wait_cnt == CW'(TIMEOUT));
  assign completion = !PRESET && (state == ACCESS) && (PREADY || timed_out);

  assign rinc = !PRESET && transfer && !resp_wfull && ((state == IDLE) || completion);

  assign resp_winc   = completion;
  assign resp_rdata  = (completion && !timed_out && !PWRITE) ? PRDATA : '0;
  assign resp_slverr = completion && (PSLVERR || timed_out);
  assign resp_write  = PWRITE;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      PPROT    <= '0;
      wait_cnt <= '0;
    end else begin
      if (rinc) begin
        PADDR  <= addr;
        PWDATA <= wdata;
        PSTRB  <= strb;
        PPROT  <= pprot;
        PWRITE <= write_read;
      end
      case (state)
        IDLE: begin
          if (rinc) begin
            state   <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (completion) begin
            // Back-to-back keeps PSEL high and goes straight to the next SETUP.
            state   <= rinc ? SETUP : IDLE;
            PSEL    <= rinc;
            PENABLE <= 1'b0;
          end else if (wait_cnt != CW'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule
